// File: rtl/ftdi_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ftdi_tx_ctrl : FTDI 245 sync-FIFO write sequencer, whole-packet bursts.  |
// | Optional macro FTDI_TIMEOUT_EN adds a TXE_N-high watchdog (oTIMEOUT).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ftdi_tx_ctrl #(
  parameter int PKT_LEN = 1024,
  parameter int GAP_CYC = 4
`ifdef FTDI_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1_000_000
`endif
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic        iEN,
  input  logic [15:0] iFIFO_Q,
  input  logic [12:0] iFIFO_USEDW,
  output logic        oFIFO_RD,
  input  logic        iTXE_N,
  output logic [15:0] oDATA,
  output logic [1:0]  oBE,
  output logic        oWR_N,
  output logic        oOE_N,
  output logic        oRD_N,
  output logic [1:0]  oGPIO,
  output logic        oBUSY,
  output logic [15:0] oPKT_CNT,
`ifdef FTDI_TIMEOUT_EN
  output logic        oTIMEOUT,
`endif
  output logic        oERR
);

  localparam int              W_CNT       = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [W_CNT-1:0] C_LAST_WORD = W_CNT'(PKT_LEN - 1);
  localparam logic [7:0]      C_LAST_GAP  = 8'(GAP_CYC - 1);
  localparam logic [12:0]     C_PKT_LEN   = 13'(PKT_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W_CNT-1:0] r_word_cnt;
  logic [7:0]       r_gap_cnt;
  logic             r_wr_n;
  logic [1:0]       r_be;
  logic [15:0]      r_data;
  logic [15:0]      r_pkt_cnt;
  logic             r_err;
  logic             w_pkt_ready;
  logic             w_start;
  logic             w_last_word;
  logic             w_last_gap;
  logic             w_fifo_rd;
  logic             w_busy;

  assign w_pkt_ready = (iFIFO_USEDW >= C_PKT_LEN);
  assign w_start     = iEN && !iTXE_N && w_pkt_ready;
  assign w_last_word = (r_word_cnt == C_LAST_WORD);
  assign w_last_gap  = (r_gap_cnt == C_LAST_GAP);

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fifo_rd   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_fifo_rd = 1'b1;
        w_busy    = 1'b1;
        if (w_last_word) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_busy = 1'b1;
        if (w_last_gap) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus registers: the show-ahead head word is captured on every read edge,
  // so WR_N trails the read acknowledge by exactly one cycle.
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_word_cnt <= '0;
      r_gap_cnt  <= '0;
      r_wr_n     <= 1'b1;
      r_be       <= 2'b00;
      r_data     <= 16'h0000;
      r_pkt_cnt  <= 16'h0000;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_SEND: begin
          r_data <= iFIFO_Q;
          r_be   <= 2'b11;
          r_wr_n <= 1'b0;
          if (w_last_word) begin
            r_word_cnt <= '0;
            r_pkt_cnt  <= r_pkt_cnt + 16'd1;
          end else begin
            r_word_cnt <= r_word_cnt + 1'b1;
          end
          // The first SEND cycle follows the TXE_N check that started the burst.
          if (iTXE_N && (r_word_cnt != '0)) r_err <= 1'b1;
        end
        S_GAP: begin
          r_wr_n    <= 1'b1;
          r_be      <= 2'b00;
          r_gap_cnt <= w_last_gap ? 8'd0 : r_gap_cnt + 8'd1;
        end
        default: begin
          r_wr_n     <= 1'b1;
          r_be       <= 2'b00;
          r_word_cnt <= '0;
          r_gap_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef FTDI_TIMEOUT_EN
  localparam logic [19:0] C_TIMEOUT = 20'(TIMEOUT_CYC);

  logic [19:0] r_to_cnt;
  logic        r_timeout;

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_to_cnt  <= 20'd0;
      r_timeout <= 1'b0;
    end else if ((r_state != S_IDLE) || !iTXE_N) begin
      r_to_cnt <= 20'd0;
    end else if (w_pkt_ready && (r_to_cnt != C_TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + 20'd1;
      if ((r_to_cnt + 20'd1) == C_TIMEOUT) r_timeout <= 1'b1;
    end
  end

  assign oTIMEOUT = r_timeout;
`endif

  assign oFIFO_RD = w_fifo_rd;
  assign oBUSY    = w_busy;
  assign oDATA    = r_data;
  assign oBE      = r_be;
  assign oWR_N    = r_wr_n;
  assign oPKT_CNT = r_pkt_cnt;
  assign oERR     = r_err;
  assign oOE_N    = 1'b1;
  assign oRD_N    = 1'b1;
  assign oGPIO    = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_ftdi_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// tb_ftdi_tx_ctrl : directed packets plus randomized FIFO/TXE_N traffic,
// checked every cycle against a packet-timeline model of the write sequencer.
module tb_ftdi_tx_ctrl;

  localparam int PKT_LEN = 1024;
  localparam int GAP_CYC = 4;

  logic        iCLK = 1'b0;
  logic        iRESET_N = 1'b0;
  logic        iEN = 1'b0;
  logic        iTXE_N = 1'b1;
  logic [15:0] iFIFO_Q = 16'h0;
  logic [12:0] iFIFO_USEDW = 13'h0;
  wire         oFIFO_RD;
  wire  [15:0] oDATA;
  wire  [1:0]  oBE;
  wire         oWR_N, oOE_N, oRD_N, oBUSY, oERR;
  wire  [1:0]  oGPIO;
  wire  [15:0] oPKT_CNT;
`ifdef FTDI_TIMEOUT_EN
  wire         oTIMEOUT;
`endif

  ftdi_tx_ctrl #(.PKT_LEN(PKT_LEN), .GAP_CYC(GAP_CYC)) dut (
    .iCLK(iCLK), .iRESET_N(iRESET_N), .iEN(iEN), .iFIFO_Q(iFIFO_Q),
    .iFIFO_USEDW(iFIFO_USEDW), .oFIFO_RD(oFIFO_RD), .iTXE_N(iTXE_N),
    .oDATA(oDATA), .oBE(oBE), .oWR_N(oWR_N), .oOE_N(oOE_N), .oRD_N(oRD_N),
    .oGPIO(oGPIO), .oBUSY(oBUSY), .oPKT_CNT(oPKT_CNT),
`ifdef FTDI_TIMEOUT_EN
    .oTIMEOUT(oTIMEOUT),
`endif
    .oERR(oERR)
  );

  always #5 iCLK = ~iCLK;

  int errors = 0;
  int checks = 0;

  // Environment and model state: m_idx is the position inside the packet
  // timeline (-1 idle, 0..PKT_LEN-1 reading, then PKT_LEN..+GAP_CYC-1 gap).
  logic [15:0] fifo[$];
  int          m_idx = -1;
  logic [15:0] m_data = 16'h0;
  logic [15:0] m_pkt = 16'h0;
  logic        m_err = 1'b0;
  logic        rd_prev = 1'b0;
  logic        nxt_en = 1'b1;
  logic        nxt_txe = 1'b0;
  int          rd_total = 0;
  int          wr_low_total = 0;
  int          wr_run = 0;
  int          wr_high_run = 0;
  logic        wr_prev = 1'b1;
  logic        seen_burst = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk_cond(input string name, input logic ok, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, req);
    end
  endtask

  task automatic cyc();
    logic        e_rd, e_wrn, e_busy;
    logic [1:0]  e_be;
    logic [41:0] act_v, exp_v;
    @(negedge iCLK);
    if (iRESET_N) begin
      if (m_idx < 0) begin
        if (iEN && !iTXE_N && (int'(iFIFO_USEDW) >= PKT_LEN)) m_idx = 0;
      end else begin
        if (m_idx < PKT_LEN) begin
          m_data = iFIFO_Q;
          if (m_idx > 0 && iTXE_N) m_err = 1'b1;
        end
        m_idx++;
        if (m_idx == PKT_LEN) m_pkt++;
        if (m_idx == PKT_LEN + GAP_CYC) m_idx = -1;
      end
      if (rd_prev && fifo.size() > 0) void'(fifo.pop_front());
    end
    e_rd   = (m_idx >= 0) && (m_idx < PKT_LEN);
    e_wrn  = !((m_idx >= 1) && (m_idx <= PKT_LEN));
    e_be   = e_wrn ? 2'b00 : 2'b11;
    e_busy = (m_idx >= 0);
    act_v = {oFIFO_RD, oWR_N, oBE, oBUSY, oERR, oOE_N, oRD_N, oGPIO, oDATA, oPKT_CNT};
    exp_v = {e_rd, e_wrn, e_be, e_busy, m_err, 1'b1, 1'b1, 2'b00, m_data, m_pkt};
    check("cycle{rd,wrn,be,busy,err,oe,rdn,gpio,data,pkt}", 64'(act_v), 64'(exp_v));

    rd_total += int'(oFIFO_RD);
    if (!oWR_N) begin
      wr_low_total++;
      if (wr_prev && seen_burst)
        chk_cond("gap_len", wr_high_run >= GAP_CYC, wr_high_run, GAP_CYC);
      seen_burst = 1'b1;
      wr_run++;
    end else begin
      if (!wr_prev) begin
        chk_cond("burst_len", wr_run == PKT_LEN, wr_run, PKT_LEN);
        wr_run = 0;
        wr_high_run = 0;
      end
      wr_high_run++;
    end
    wr_prev = oWR_N;
    rd_prev = iRESET_N ? oFIFO_RD : 1'b0;

    iEN = nxt_en;
    iTXE_N = nxt_txe;
    iFIFO_USEDW = 13'(fifo.size());
    iFIFO_Q = (fifo.size() > 0) ? fifo[0] : 16'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, wr0, txe_hold;
    repeat (3) cyc();
    check("reset_state", 64'({oWR_N, oFIFO_RD, oDATA, oBE, oBUSY, oPKT_CNT, oERR, oOE_N, oRD_N, oGPIO}),
          64'({1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 2'b00}));
    iRESET_N = 1'b1;

    // One full packet of 0..1023.
    rd0 = rd_total; wr0 = wr_low_total;
    for (int i = 0; i < PKT_LEN; i++) fifo.push_back(16'(i));
    repeat (1100) cyc();
    check("t1_rd_count", 64'(rd_total - rd0), 64'd1024);
    check("t1_wr_low_count", 64'(wr_low_total - wr0), 64'd1024);
    check("t1_last_data", 64'(oDATA), 64'd1023);
    check("t1_pkt_cnt", 64'(oPKT_CNT), 64'd1);
    check("t1_err", 64'(oERR), 64'd0);

    // One word short: nothing may start until the last word arrives.
    rd0 = rd_total; wr0 = wr_low_total;
    for (int i = 0; i < PKT_LEN - 1; i++) fifo.push_back(16'h1000 + 16'(i));
    repeat (50) cyc();
    check("t2_partial_rd", 64'(rd_total - rd0), 64'd0);
    check("t2_partial_wr", 64'(wr_low_total - wr0), 64'd0);
    fifo.push_back(16'h1FFF);
    cyc();
    check("t2_before_start", 64'(oFIFO_RD), 64'd0);
    cyc();
    check("t2_start_latency", 64'(oFIFO_RD), 64'd1);
    repeat (1100) cyc();
    check("t2_pkt_cnt", 64'(oPKT_CNT), 64'd2);
    check("t2_last_data", 64'(oDATA), 64'h1FFF);

    // TXE_N glitch mid-burst: the burst continues and the error sticks.
    for (int i = 0; i < PKT_LEN; i++) fifo.push_back(16'($urandom));
    for (int i = 0; i < 600 && m_idx != 500; i++) cyc();
    chk_cond("t3_reach_word500", m_idx == 500, m_idx, 500);
    nxt_txe = 1'b1;
    cyc();
    nxt_txe = 1'b0;
    repeat (1100) cyc();
    check("t3_err", 64'(oERR), 64'd1);
    check("t3_pkt_cnt", 64'(oPKT_CNT), 64'd3);
    repeat (20) cyc();
    check("t3_err_sticky", 64'(oERR), 64'd1);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < PKT_LEN; i++) fifo.push_back(16'($urandom));
    for (int i = 0; i < 400 && m_idx != 300; i++) cyc();
    chk_cond("t4_reach_word300", m_idx == 300, m_idx, 300);
    #2 iRESET_N = 1'b0;
    #1 check("t4_async_reset", 64'({oWR_N, oFIFO_RD, oBUSY, oPKT_CNT, oERR}),
             64'({1'b1, 1'b0, 1'b0, 16'h0, 1'b0}));
    m_idx = -1; m_data = 16'h0; m_pkt = 16'h0; m_err = 1'b0;
    fifo.delete();
    rd_prev = 1'b0; wr_prev = 1'b1; wr_run = 0; wr_high_run = 0; seen_burst = 1'b0;
    repeat (2) cyc();
    iRESET_N = 1'b1;
    cyc();
    check("t4_after_release", 64'({oPKT_CNT, oBUSY, oWR_N}), 64'({16'h0, 1'b0, 1'b1}));

    // Random traffic: FTDI holds TXE_N high for a while after each packet.
    txe_hold = 0;
    for (int c = 0; c < 9000; c++) begin
      nxt_en = ($urandom_range(0, 15) != 0);
      if (m_idx == PKT_LEN) txe_hold = $urandom_range(30, 200);
      if (txe_hold > 0) begin
        nxt_txe = 1'b1;
        txe_hold--;
      end else begin
        nxt_txe = ($urandom_range(0, 299) == 0);
      end
      if (fifo.size() < 3000 && $urandom_range(0, 7) != 0) fifo.push_back(16'($urandom));
      cyc();
    end
    chk_cond("rand_pkts", oPKT_CNT >= 16'd2, int'(oPKT_CNT), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
